// File: rtl/dlx_pkg.sv
// Shared definitions for the DLX instruction fetch slice.
package dlx_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] PC_INC  = 32'd4;
    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO holding fetched {pc, instruction} pairs; head is read straight from storage.
module fetch_fifo
    import dlx_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  logic [31:0]        push_pc_i,
    input  logic [INSTR_W-1:0] push_ins_i,
    output logic [CNT_W-1:0]   count_o,
    output logic [31:0]        head_pc_o,
    output logic [INSTR_W-1:0] head_ins_o,
    output logic               valid_o
);

    logic [31:0]        pc_mem_q  [DEPTH];
    logic [INSTR_W-1:0] ins_mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;

    // Pointer width equals log2(DEPTH), so increments wrap for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]  <= '0;
                ins_mem_q[i] <= NOP;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                pc_mem_q[wr_ptr_q]  <= push_pc_i;
                ins_mem_q[wr_ptr_q] <= push_ins_i;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    assign count_o    = count_q;
    assign valid_o    = (count_q != '0);
    assign head_pc_o  = pc_mem_q[rd_ptr_q];
    assign head_ins_o = ins_mem_q[rd_ptr_q];

endmodule

// File: rtl/dlx_ifetch.sv
// DLX fetch unit: one outstanding imem request, FIFO of returned words, redirect flush/squash.
module dlx_ifetch
    import dlx_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               ins_valid,
    output logic [INSTR_W-1:0] ins,
    output logic [31:0]        ins_pc,
    input  logic               ins_ready,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             push, pop, has_space;
    logic [31:0]      redirect_pc_aligned;

    assign redirect_pc_aligned = redirect_pc & ~32'h3;

    assign push = (state_q == WAIT) && imem_rvalid && !redirect;
    assign pop  = ins_valid && ins_ready && !redirect;

    always_comb begin
        count_next = count + CNT_W'(push) - CNT_W'(pop);
        if (redirect) begin
            count_next = '0;
        end
    end

    assign has_space = (count_next < CNT_W'(DEPTH));

    // Redirect dominates: a granted or in-flight fetch must still drain its response in DROP.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        unique case (state_q)
            IDLE: begin
                if (redirect || has_space) state_d = REQ;
            end
            REQ: begin
                if (imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_INC;
                    state_d  = redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) state_d = has_space ? REQ : IDLE;
                else if (redirect) state_d = DROP;
            end
            DROP: begin
                if (imem_rvalid) state_d = has_space ? REQ : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            pc_d = redirect_pc_aligned;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign imem_req  = (state_q == REQ);
    assign imem_addr = pc_q;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (push),
        .pop_i      (pop),
        .flush_i    (redirect),
        .push_pc_i  (req_pc_q),
        .push_ins_i (imem_rdata),
        .count_o    (count),
        .head_pc_o  (ins_pc),
        .head_ins_o (ins),
        .valid_o    (ins_valid)
    );

endmodule
